// File: rtl/ddr4_db_sched_pkg.sv
// Shared types and helpers for the DDR4 data-buffer direction scheduler.
// Contents: direction enum, countdown slot payload, window-length helper.
package ddr4_db_sched_pkg;

  localparam int unsigned LAT_W = 6;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } dir_e;

  typedef struct packed {
    logic             valid;
    dir_e             dir;
    logic [LAT_W-1:0] cnt;
  } slot_t;

  // Drive window length: preamble + burst body (BL/2 clocks) + postamble.
  function automatic int unsigned win_len(input int unsigned pre,
                                          input int unsigned bl,
                                          input int unsigned post);
    return pre + bl / 2 + post;
  endfunction

endpackage

// File: rtl/ddr4_db_dir_slot.sv
// One outstanding-burst countdown slot.
// Ports:
//   ddr4_ck_t, ddr4_reset_n : clock, synchronous active-low reset
//   i_load, i_dir, i_cnt    : capture a new burst with its start countdown
//   o_valid                 : slot holds a pending burst
//   o_fire_c                : combinational; countdown reaches 0 on this edge
//   o_dir                   : direction of the pending burst
module ddr4_db_dir_slot
  import ddr4_db_sched_pkg::*;
(
  input  logic             ddr4_ck_t,
  input  logic             ddr4_reset_n,
  input  logic             i_load,
  input  dir_e             i_dir,
  input  logic [LAT_W-1:0] i_cnt,
  output logic             o_valid,
  output logic             o_fire_c,
  output dir_e             o_dir
);

  slot_t r_slot;

  // A count of 1 reaches 0 on this edge, so the slot fires and frees now.
  assign o_fire_c = r_slot.valid && (r_slot.cnt == LAT_W'(1));
  assign o_valid  = r_slot.valid;
  assign o_dir    = r_slot.dir;

  // Load wins over fire so a slot freed on this edge can be reused at once.
  always_ff @(posedge ddr4_ck_t) begin
    if (!ddr4_reset_n) begin
      r_slot <= '0;
    end else if (i_load) begin
      r_slot <= '{valid: 1'b1, dir: i_dir, cnt: i_cnt};
    end else if (o_fire_c) begin
      r_slot <= '{valid: 1'b0, dir: r_slot.dir, cnt: '0};
    end else if (r_slot.valid) begin
      r_slot.cnt <= r_slot.cnt - LAT_W'(1);
    end
  end

endmodule

// File: rtl/ddr4_db_dir_sched.sv
// Command-driven direction scheduler for the DDR4 DB DQ/DQS delay path.
// Ports:
//   ddr4_ck_t, ddr4_reset_n      : clock, synchronous active-low reset
//   cmd_valid, cmd_is_wr         : accepted RD/WR command strobe and type
//   cfg_cl, cfg_cwl              : read / write latency in clocks
//   cfg_nibble_en                : per-nibble output enable mask
//   wrlvl_en                     : write-leveling override
//   dqs_/dq_ wr_/rd_ drive       : registered per-nibble direction enables
//   busy                         : slot pending or window active
//   ovf_err, conflict_err        : sticky error flags
module ddr4_db_dir_sched
  import ddr4_db_sched_pkg::*;
#(
  parameter int unsigned NUM_NIBBLES = 4,
  parameter int unsigned SLOTS       = 4,
  parameter int unsigned BL          = 8,
  parameter int unsigned PRE_WR      = 1,
  parameter int unsigned PRE_RD      = 1,
  parameter int unsigned POST        = 1
) (
  input  logic                   ddr4_ck_t,
  input  logic                   ddr4_reset_n,
  input  logic                   cmd_valid,
  input  logic                   cmd_is_wr,
  input  logic [LAT_W-1:0]       cfg_cl,
  input  logic [LAT_W-1:0]       cfg_cwl,
  input  logic [NUM_NIBBLES-1:0] cfg_nibble_en,
  input  logic                   wrlvl_en,
  output logic [NUM_NIBBLES-1:0] dqs_wr_drive,
  output logic [NUM_NIBBLES-1:0] dqs_rd_drive,
  output logic [NUM_NIBBLES-1:0] dq_wr_drive,
  output logic [NUM_NIBBLES-1:0] dq_rd_drive,
  output logic                   busy,
  output logic                   ovf_err,
  output logic                   conflict_err
);

  localparam int unsigned WIN_WR = win_len(PRE_WR, BL, POST);
  localparam int unsigned WIN_RD = win_len(PRE_RD, BL, POST);

  logic [SLOTS-1:0]       w_valid, w_fire, w_free, w_load;
  dir_e                   w_slot_dir [SLOTS];
  logic [LAT_W:0]         w_lat, w_pre;
  logic [LAT_W-1:0]       w_start;
  logic                   w_found, w_cmd, w_drop;
  logic                   w_fire_wr, w_fire_rd, w_any_fire, w_active;
  logic [LAT_W-1:0]       w_cnt_nxt;
  dir_e                   w_dir_nxt;
  logic                   w_busy_nxt, w_conf_nxt;
  logic [NUM_NIBBLES-1:0] w_wr_mask, w_rd_mask;

  logic [LAT_W-1:0]       r_win_cnt;
  dir_e                   r_dir;

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    ddr4_db_dir_slot u_slot (
      .ddr4_ck_t    (ddr4_ck_t),
      .ddr4_reset_n (ddr4_reset_n),
      .i_load       (w_load[g]),
      .i_dir        (dir_e'(cmd_is_wr)),
      .i_cnt        (w_start),
      .o_valid      (w_valid[g]),
      .o_fire_c     (w_fire[g]),
      .o_dir        (w_slot_dir[g])
    );
  end

  assign w_free = ~w_valid | w_fire;
  assign w_cmd  = cmd_valid && !wrlvl_en;
  assign w_drop = w_cmd && !w_found;

  // Start offset S = max(lat - pre, 2), computed one bit wider to avoid wrap.
  always_comb begin
    w_lat   = {1'b0, (cmd_is_wr ? cfg_cwl : cfg_cl)};
    w_pre   = cmd_is_wr ? (LAT_W+1)'(PRE_WR) : (LAT_W+1)'(PRE_RD);
    w_start = LAT_W'(2);
    if (w_lat >= w_pre + (LAT_W+1)'(2)) begin
      w_start = LAT_W'(w_lat - w_pre);
    end
  end

  // Lowest free slot takes the command.
  always_comb begin
    w_load  = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (w_free[i] && !w_found) begin
        w_load[i] = w_cmd;
        w_found   = 1'b1;
      end
    end
  end

  // Fire arbitration and window counter next state; WR wins a same-edge tie.
  always_comb begin
    w_fire_wr = 1'b0;
    w_fire_rd = 1'b0;
    for (int unsigned i = 0; i < SLOTS; i++) begin
      if (w_fire[i]) begin
        if (w_slot_dir[i] == DIR_WR) w_fire_wr = 1'b1;
        else                         w_fire_rd = 1'b1;
      end
    end
    w_any_fire = w_fire_wr || w_fire_rd;
    w_active   = (r_win_cnt != '0);
    w_dir_nxt  = r_dir;
    w_cnt_nxt  = w_active ? r_win_cnt - LAT_W'(1) : '0;
    if (w_any_fire) begin
      w_dir_nxt = w_fire_wr ? DIR_WR : DIR_RD;
      w_cnt_nxt = w_fire_wr ? LAT_W'(WIN_WR) : LAT_W'(WIN_RD);
    end
    w_conf_nxt = conflict_err || (w_fire_wr && w_fire_rd) ||
                 (w_any_fire && w_active && (w_dir_nxt != r_dir));
    w_busy_nxt = (|(w_valid & ~w_fire)) || (|w_load) || (w_cnt_nxt != '0);
    w_wr_mask  = ((w_cnt_nxt != '0) && (w_dir_nxt == DIR_WR)) ? cfg_nibble_en : '0;
    w_rd_mask  = ((w_cnt_nxt != '0) && (w_dir_nxt == DIR_RD)) ? cfg_nibble_en : '0;
  end

  // Window state, registered drives and sticky errors.
  always_ff @(posedge ddr4_ck_t) begin
    if (!ddr4_reset_n) begin
      r_win_cnt    <= '0;
      r_dir        <= DIR_RD;
      dqs_wr_drive <= '0;
      dqs_rd_drive <= '0;
      dq_wr_drive  <= '0;
      dq_rd_drive  <= '0;
      busy         <= 1'b0;
      ovf_err      <= 1'b0;
      conflict_err <= 1'b0;
    end else begin
      r_win_cnt    <= w_cnt_nxt;
      r_dir        <= w_dir_nxt;
      busy         <= w_busy_nxt;
      ovf_err      <= ovf_err || w_drop;
      conflict_err <= w_conf_nxt;
      if (wrlvl_en) begin
        // Leveling: controller drives DQS, SDRAM returns feedback on DQ.
        dqs_wr_drive <= cfg_nibble_en;
        dqs_rd_drive <= '0;
        dq_wr_drive  <= '0;
        dq_rd_drive  <= cfg_nibble_en;
      end else begin
        dqs_wr_drive <= w_wr_mask;
        dqs_rd_drive <= w_rd_mask;
        dq_wr_drive  <= w_wr_mask;
        dq_rd_drive  <= w_rd_mask;
      end
    end
  end

endmodule

// File: tb/tb_ddr4_db_dir_sched.sv
// Self-checking bench for ddr4_db_dir_sched: directed scenarios plus random
// traffic, all compared every cycle against an edge-indexed reference model.
module tb_ddr4_db_dir_sched;

  localparam int NN     = 4;
  localparam int SLOTS  = 4;
  localparam int BL     = 8;
  localparam int PRE_WR = 1;
  localparam int PRE_RD = 1;
  localparam int POST   = 1;
  localparam int VW     = 4 * NN + 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_is_wr = 1'b0;
  logic [5:0]    cfg_cl = 6'd11;
  logic [5:0]    cfg_cwl = 6'd9;
  logic [NN-1:0] cfg_nibble_en = '1;
  logic          wrlvl_en = 1'b0;
  logic [NN-1:0] dqs_wr_drive, dqs_rd_drive, dq_wr_drive, dq_rd_drive;
  logic          busy, ovf_err, conflict_err;
  logic [VW-1:0] w_act;

  int errors = 0;
  int checks = 0;

  ddr4_db_dir_sched #(
    .NUM_NIBBLES (NN), .SLOTS (SLOTS), .BL (BL),
    .PRE_WR (PRE_WR), .PRE_RD (PRE_RD), .POST (POST)
  ) dut (
    .ddr4_ck_t     (clk),
    .ddr4_reset_n  (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_is_wr     (cmd_is_wr),
    .cfg_cl        (cfg_cl),
    .cfg_cwl       (cfg_cwl),
    .cfg_nibble_en (cfg_nibble_en),
    .wrlvl_en      (wrlvl_en),
    .dqs_wr_drive  (dqs_wr_drive),
    .dqs_rd_drive  (dqs_rd_drive),
    .dq_wr_drive   (dq_wr_drive),
    .dq_rd_drive   (dq_rd_drive),
    .busy          (busy),
    .ovf_err       (ovf_err),
    .conflict_err  (conflict_err)
  );

  always #5 clk = ~clk;

  assign w_act = {dqs_wr_drive, dqs_rd_drive, dq_wr_drive, dq_rd_drive,
                  busy, ovf_err, conflict_err};

  // Reference model: pending bursts keyed by absolute fire edge, window kept
  // as the last edge whose following cycle is driven.
  typedef struct {int fe; bit wr;} pend_t;
  pend_t         pq[$];
  int            m_edge = 0;
  int            m_hi   = -1000;
  bit            m_dir, m_ovf, m_conf, m_wl;
  logic [NN-1:0] m_mask;

  task automatic model_edge();
    bit fw, fr, act_before;
    int lat, s;
    m_edge++;
    if (!rst_n) begin
      pq.delete();
      m_hi = -1000; m_dir = 0; m_ovf = 0; m_conf = 0; m_wl = 0; m_mask = '0;
      return;
    end
    act_before = (m_edge - 1 <= m_hi);
    fw = 0; fr = 0;
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].fe == m_edge) begin
        if (pq[i].wr) fw = 1; else fr = 1;
        pq.delete(i);
      end
    end
    if (fw || fr) begin
      if (fw && fr) m_conf = 1;
      if (act_before && (fw != m_dir)) m_conf = 1;
      m_dir = fw;
      m_hi  = m_edge + (fw ? PRE_WR : PRE_RD) + BL / 2 + POST - 1;
    end
    if (cmd_valid && !wrlvl_en) begin
      if (pq.size() < SLOTS) begin
        lat = cmd_is_wr ? int'(cfg_cwl) : int'(cfg_cl);
        s = lat - (cmd_is_wr ? PRE_WR : PRE_RD);
        if (s < 2) s = 2;
        pq.push_back('{m_edge + s, cmd_is_wr});
      end else begin
        m_ovf = 1;
      end
    end
    m_wl   = wrlvl_en;
    m_mask = cfg_nibble_en;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    logic          act;
    logic [NN-1:0] wr, rd, z;
    act = (m_edge <= m_hi);
    z   = '0;
    wr  = (act && m_dir)  ? m_mask : z;
    rd  = (act && !m_dir) ? m_mask : z;
    if (m_wl) return {m_mask, z, z, m_mask, (pq.size() != 0) || act, m_ovf, m_conf};
    return {wr, rd, wr, rd, (pq.size() != 0) || act, m_ovf, m_conf};
  endfunction

  // One clock edge: model follows the DUT, outputs then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; wrlvl_en = 1'b0; cfg_nibble_en = '1;
    cfg_cl = 6'd11; cfg_cwl = 6'd9;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] e;
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_is_wr = 1'b1; wrlvl_en = 1'b0;
    repeat (3) begin
      tick();
      e = exp_vec();
      checks++;
      if (w_act !== '0 || e !== '0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", m_edge, w_act, e);
      end
    end
    cmd_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_single_wr();
    logic [VW-1:0] e;
    int wr_cyc = 0, rd_cyc = 0;
    do_reset();
    cmd_valid = 1'b1; cmd_is_wr = 1'b1;
    for (int c = 0; c < 18; c++) begin
      tick();
      cmd_valid = 1'b0;
      e = exp_vec();
      checks++;
      if (w_act !== e) begin
        errors++;
        $display("FAIL single_wr cyc=%0d got=%h exp=%h", c, w_act, e);
      end
      if (dq_wr_drive != '0) wr_cyc++;
      if (dq_rd_drive != '0) rd_cyc++;
    end
    checks++;
    if (wr_cyc != 6 || rd_cyc != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_wr_len got wr=%0d rd=%0d busy=%b exp wr=6 rd=0 busy=0",
               wr_cyc, rd_cyc, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] e;
    int rd_cyc = 0;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      cmd_valid = (c == 0 || c == 4); cmd_is_wr = 1'b0;
      tick();
      e = exp_vec();
      checks++;
      if (w_act !== e) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", c, w_act, e);
      end
      if (dq_rd_drive != '0) rd_cyc++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (rd_cyc != 10 || conflict_err !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_len got rd=%0d conf=%b exp rd=10 conf=0", rd_cyc, conflict_err);
    end
  endtask

  task automatic test_conflict();
    logic [VW-1:0] e;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      cmd_valid = (c < 2); cmd_is_wr = (c == 1);
      tick();
      e = exp_vec();
      checks++;
      if (w_act !== e) begin
        errors++;
        $display("FAIL conflict cyc=%0d got=%h exp=%h", c, w_act, e);
      end
    end
    cmd_valid = 1'b0;
    checks++;
    if (conflict_err !== 1'b1) begin
      errors++;
      $display("FAIL conflict_flag got=%b exp=1", conflict_err);
    end
  endtask

  task automatic test_overflow();
    logic [VW-1:0] e;
    int rd_cyc = 0;
    do_reset();
    cfg_cl = 6'd20;
    for (int c = 0; c < 34; c++) begin
      cmd_valid = (c < 5); cmd_is_wr = 1'b0;
      tick();
      e = exp_vec();
      checks++;
      if (w_act !== e) begin
        errors++;
        $display("FAIL overflow cyc=%0d got=%h exp=%h", c, w_act, e);
      end
      if (dq_rd_drive != '0) rd_cyc++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (ovf_err !== 1'b1 || rd_cyc != 9) begin
      errors++;
      $display("FAIL overflow_flag got ovf=%b rd=%0d exp ovf=1 rd=9", ovf_err, rd_cyc);
    end
  endtask

  task automatic test_wrlvl();
    logic [VW-1:0] e;
    int win_cyc = 0;
    do_reset();
    cfg_nibble_en = 4'b0101;
    wrlvl_en = 1'b1;
    for (int c = 0; c < 30; c++) begin
      cmd_valid = (c == 2); cmd_is_wr = 1'b1;
      if (c == 12) wrlvl_en = 1'b0;
      tick();
      e = exp_vec();
      checks++;
      if (w_act !== e) begin
        errors++;
        $display("FAIL wrlvl cyc=%0d got=%h exp=%h", c, w_act, e);
      end
      if (c == 5) begin
        checks++;
        if ({dqs_wr_drive, dqs_rd_drive, dq_wr_drive, dq_rd_drive} !== 16'h5005) begin
          errors++;
          $display("FAIL wrlvl_force got=%h exp=5005",
                   {dqs_wr_drive, dqs_rd_drive, dq_wr_drive, dq_rd_drive});
        end
      end
      if (c > 12 && dq_wr_drive != '0) win_cyc++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (win_cyc != 0) begin
      errors++;
      $display("FAIL wrlvl_cmd got=%0d window cycles exp=0", win_cyc);
    end
  endtask

  task automatic test_mid_reset();
    logic [VW-1:0] e;
    int wr_cyc = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      cmd_valid = (c == 0); cmd_is_wr = 1'b1;
      rst_n = (c != 5);
      tick();
      e = exp_vec();
      checks++;
      if (w_act !== e) begin
        errors++;
        $display("FAIL mid_reset cyc=%0d got=%h exp=%h", c, w_act, e);
      end
      if (c >= 5 && w_act != '0) wr_cyc++;
    end
    rst_n = 1'b1; cmd_valid = 1'b0;
    checks++;
    if (wr_cyc != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet got=%0d active cycles exp=0", wr_cyc);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_is_wr = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) begin
        cfg_cl  = 6'($urandom_range(1, 25));
        cfg_cwl = 6'($urandom_range(1, 25));
      end
      cfg_nibble_en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if ($urandom_range(0, 99) == 0) wrlvl_en = ~wrlvl_en;
      rst_n = ($urandom_range(0, 299) != 0);
      tick();
      e = exp_vec();
      checks++;
      if (w_act !== e) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, w_act, e);
      end
    end
    rst_n = 1'b1; cmd_valid = 1'b0; wrlvl_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_wr();
    test_back_to_back();
    test_conflict();
    test_overflow();
    test_wrlvl();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
